// File: rtl/arith_pkg.sv
// Shared types and constants for the byte-serial adder sequencer.
package arith_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte index width, never narrower than one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/adder_8bit.sv
// Shared 8-bit ripple-carry adder slice.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    always_comb begin
        c[0] = cin;
        sum  = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[8];
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder sequencer: one byte slice per clock, carry chained
// through a register, valid/ready on both request and result ports.
module adder_seq_ctrl
    import arith_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = idx_width(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t          state;
    state_t          next;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [IW-1:0]   idx;
    logic            carry_r;
    logic [7:0]      slice_sum;
    logic            slice_cout;
    logic            accept;
    logic            last;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (idx == LAST);

    adder_8bit u_slice (
        .a    (a_r[BYTE_W*idx +: BYTE_W]),
        .b    (b_r[BYTE_W*idx +: BYTE_W]),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next      = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            idx     <= '0;
            carry_r <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            idx     <= '0;
            carry_r <= cin;
            sum     <= '0;
        end else if (state == RUN) begin
            sum[BYTE_W*idx +: BYTE_W] <= slice_sum;
            carry_r <= slice_cout;
            if (last) begin
                cout <= slice_cout;
                // Sign overflow: equal operand signs, differing result sign.
                ovf  <= (a_r[W-1] == b_r[W-1]) &&
                        (slice_sum[7] != a_r[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
